// File: rtl/processor_pkg.sv
// Shared definitions for the 9-bit processor and its instruction feeder:
// word/address widths, opcode constants and the feeder state encoding.
package processor_pkg;

    localparam int DATA_W = 9;
    localparam int ADDR_W = 6;

    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVI = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LATCH,
        S_ISSUE,
        S_WAIT,
        S_FINISH,
        S_ERROR
    } feeder_state_t;

    // Opcode field of an IIIXXXYYY word.
    function automatic logic [2:0] opcode_of(input logic [DATA_W-1:0] w);
        return w[DATA_W-1 -: 3];
    endfunction

endpackage

// File: rtl/instr_feeder_if.sv
// Bus between the feeder, the program ROM and the processor.
// master: feeder (drives imem_addr, DataOut, Run); slave: ROM + processor.
interface instr_feeder_if #(
    parameter int DATA_W = processor_pkg::DATA_W,
    parameter int ADDR_W = processor_pkg::ADDR_W
);

    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_rdata;
    logic [DATA_W-1:0] DataOut;
    logic              Run;
    logic              Done;

    modport master (
        output imem_addr,
        output DataOut,
        output Run,
        input  imem_rdata,
        input  Done
    );

    modport slave (
        input  imem_addr,
        input  DataOut,
        input  Run,
        output imem_rdata,
        output Done
    );

endinterface

// File: rtl/feeder_wait_timer.sv
// Counts WAIT cycles spent without Done; flags the cycle that uses up
// the budget. Ports: clock, aResetn, clr, en in; timeout out.
module feeder_wait_timer #(
    parameter int MAX_WAIT = 15
) (
    input  logic clock,
    input  logic aResetn,
    input  logic clr,
    input  logic en,
    output logic timeout
);

    localparam int CW = $clog2(MAX_WAIT + 1);

    logic [CW-1:0] cnt;
    logic          at_last;

    // cnt counts completed idle cycles, so the MAX_WAIT-th idle
    // cycle is the one where cnt == MAX_WAIT-1.
    assign at_last = (cnt == CW'(MAX_WAIT - 1));
    assign timeout = en && at_last;

    always_ff @(posedge clock or negedge aResetn) begin
        if (!aResetn) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !at_last) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/instr_feeder.sv
// Drives the processor's Run/Done/DataIn interface from a synchronous ROM.
// Ports: clock, aResetn, start, prog_len; bus (master); busy, finished,
// timeout_err, instr_count status outputs.
module instr_feeder
    import processor_pkg::*;
#(
    parameter int         DATA_W   = processor_pkg::DATA_W,
    parameter int         ADDR_W   = processor_pkg::ADDR_W,
    parameter int         MAX_WAIT = 15,
    parameter logic [2:0] OP_MVI   = processor_pkg::OP_MVI
) (
    input  logic              clock,
    input  logic              aResetn,
    input  logic              start,
    input  logic [ADDR_W:0]   prog_len,
    instr_feeder_if.master    bus,
    output logic              busy,
    output logic              finished,
    output logic              timeout_err,
    output logic [ADDR_W:0]   instr_count
);

    localparam int PW = ADDR_W + 1;

    feeder_state_t state_q;
    feeder_state_t state_d;

    logic [PW-1:0]     pc_q;
    logic [PW-1:0]     pc_nxt_q;
    logic [PW-1:0]     len_q;
    logic [PW-1:0]     count_q;
    logic [DATA_W-1:0] dout_q;
    logic              run_q;

    logic              is_mvi;
    logic              accept_start;
    logic              retire;
    logic              load_dout;
    logic              run_d;
    logic              wait_clr;
    logic              wait_en;
    logic              wait_timeout;
    logic [ADDR_W-1:0] pc_lo;
    logic [ADDR_W-1:0] pc_lo_inc;

    // In ISSUE, DataOut still holds the instruction word.
    assign is_mvi = (opcode_of(dout_q) == OP_MVI);

    // ROM address wraps modulo 2^ADDR_W.
    assign pc_lo     = pc_q[ADDR_W-1:0];
    assign pc_lo_inc = pc_lo + ADDR_W'(1);

    feeder_wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_timer (
        .clock   (clock),
        .aResetn (aResetn),
        .clr     (wait_clr),
        .en      (wait_en),
        .timeout (wait_timeout)
    );

    // State register.
    always_ff @(posedge clock or negedge aResetn) begin
        if (!aResetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_ERROR: begin
                if (start) begin
                    state_d = (prog_len == '0) ? S_FINISH : S_FETCH;
                end
            end
            S_FETCH:  state_d = S_LATCH;
            S_LATCH:  state_d = S_ISSUE;
            S_ISSUE:  state_d = S_WAIT;
            S_WAIT: begin
                if (bus.Done) begin
                    state_d = (pc_nxt_q >= len_q) ? S_FINISH : S_FETCH;
                end else if (wait_timeout) begin
                    state_d = S_ERROR;
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Output / control decode.
    always_comb begin
        accept_start = 1'b0;
        retire       = 1'b0;
        load_dout    = 1'b0;
        run_d        = 1'b0;
        wait_clr     = 1'b0;
        wait_en      = 1'b0;
        busy         = 1'b0;
        finished     = 1'b0;
        timeout_err  = 1'b0;
        bus.imem_addr = pc_lo;
        unique case (state_q)
            S_IDLE: begin
                accept_start = start;
            end
            S_FETCH: begin
                busy = 1'b1;
            end
            S_LATCH: begin
                busy          = 1'b1;
                load_dout     = 1'b1;
                run_d         = 1'b1;
                bus.imem_addr = pc_lo_inc;
            end
            S_ISSUE: begin
                busy          = 1'b1;
                load_dout     = is_mvi;
                wait_clr      = 1'b1;
                bus.imem_addr = pc_lo_inc;
            end
            S_WAIT: begin
                busy    = 1'b1;
                retire  = bus.Done;
                wait_en = !bus.Done;
            end
            S_FINISH: begin
                finished = 1'b1;
            end
            S_ERROR: begin
                timeout_err  = 1'b1;
                accept_start = start;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // Datapath registers. Run is registered so it is a clean
    // single-cycle pulse in ISSUE and drops at once on reset.
    always_ff @(posedge clock or negedge aResetn) begin
        if (!aResetn) begin
            pc_q     <= '0;
            pc_nxt_q <= '0;
            len_q    <= '0;
            count_q  <= '0;
            dout_q   <= '0;
            run_q    <= 1'b0;
        end else begin
            run_q <= run_d;
            if (load_dout) begin
                dout_q <= bus.imem_rdata;
            end
            if (accept_start) begin
                pc_q    <= '0;
                count_q <= '0;
                len_q   <= prog_len;
            end
            if (state_q == S_ISSUE) begin
                pc_nxt_q <= pc_q + (is_mvi ? PW'(2) : PW'(1));
            end
            if (retire) begin
                pc_q    <= pc_nxt_q;
                count_q <= count_q + PW'(1);
            end
        end
    end

    assign bus.DataOut = dout_q;
    assign bus.Run     = run_q;
    assign instr_count = count_q;

endmodule
